// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a 1-bit valid/ready
// stream and buffers them in a DEPTH-entry FIFO behind a parallel valid/ready port.
module serial_word_rx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             sclk_i,
  input  logic             rst_i,
  input  logic             data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic             busy_o
);

  localparam int unsigned BitCntW = $clog2(WIDTH);
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CountW  = PtrW + 1;

  localparam logic [BitCntW-1:0] LastBit = BitCntW'(WIDTH - 1);
  localparam logic [CountW-1:0]  Full    = CountW'(DEPTH);

  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]  count_q, count_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

  logic             last_bit;
  logic             accept;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] shift_in;

  // ready_o depends only on registered state, so only the word-completing bit can stall.
  always_comb begin
    last_bit = (bit_cnt_q == LastBit);
    ready_o  = !last_bit || (count_q != Full);
    accept   = valid_i && ready_o;
    push     = accept && last_bit;
    valid_o  = (count_q != '0);
    pop      = valid_o && ready_i;
    shift_in = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], data_i} : {data_i, shift_q[WIDTH-1:1]};
    data_o   = valid_o ? mem_q[rd_ptr_q] : '0;
    busy_o   = (bit_cnt_q != '0);
    word_cnt_o = word_cnt_q;
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;

    if (accept) begin
      shift_d   = shift_in;
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + BitCntW'(1);
    end
    if (push) begin
      mem_d[wr_ptr_q] = shift_in;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
      word_cnt_d      = word_cnt_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sclk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: an MSB-first/CNT_W=16 and an LSB-first/CNT_W=2 instance share
// stimulus; a word-level queue model predicts both every cycle.
module tb_serial_word_rx;

  logic sclk = 1'b0;
  logic rst = 1'b1;
  logic data_i = 1'b0;
  logic valid_i = 1'b0;
  logic ready_i = 1'b0;

  logic        ready_a, valid_a, busy_a;
  logic [7:0]  data_a;
  logic [15:0] cnt_a;
  logic        ready_b, valid_b, busy_b;
  logic [7:0]  data_b;
  logic [1:0]  cnt_b;

  int vectors = 0;
  int errors  = 0;

  // Reference model: bits received so far in the current word, partial words, word queues.
  int          k = 0;
  logic [7:0]  wa = 8'h00;
  logic [7:0]  wb = 8'h00;
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  int unsigned total = 0;

  always #5 sclk = ~sclk;

  serial_word_rx #(.WIDTH(8), .MSB_FIRST(1), .DEPTH(2), .CNT_W(16)) dut_a (
    .sclk_i(sclk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_a),
    .data_o(data_a), .valid_o(valid_a), .ready_i(ready_i), .word_cnt_o(cnt_a), .busy_o(busy_a)
  );

  serial_word_rx #(.WIDTH(8), .MSB_FIRST(0), .DEPTH(2), .CNT_W(2)) dut_b (
    .sclk_i(sclk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_b),
    .data_o(data_b), .valid_o(valid_b), .ready_i(ready_i), .word_cnt_o(cnt_b), .busy_o(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ready();
    return (k != 7) || (qa.size() != 2);
  endfunction

  task automatic check_all();
    logic [7:0] ea, eb;
    ea = (qa.size() != 0) ? qa[0] : 8'h00;
    eb = (qb.size() != 0) ? qb[0] : 8'h00;
    chk("ready_a", 32'(ready_a), 32'(m_ready()));
    chk("ready_b", 32'(ready_b), 32'(m_ready()));
    chk("valid_a", 32'(valid_a), 32'(qa.size() != 0));
    chk("valid_b", 32'(valid_b), 32'(qb.size() != 0));
    chk("data_a", 32'(data_a), 32'(ea));
    chk("data_b", 32'(data_b), 32'(eb));
    chk("cnt_a", 32'(cnt_a), total % 65536);
    chk("cnt_b", 32'(cnt_b), total % 4);
    chk("busy_a", 32'(busy_a), 32'(k != 0));
    chk("busy_b", 32'(busy_b), 32'(k != 0));
  endtask

  // One clock: drive inputs, predict, advance past the edge, compare everything.
  task automatic cyc(input logic v, input logic d, input logic r);
    logic acc, pop;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    acc = v && m_ready();
    pop = r && (qa.size() != 0);
    @(posedge sclk);
    #1;
    if (pop) begin
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    if (acc) begin
      if (k == 0) begin
        wa = 8'h00;
        wb = 8'h00;
      end
      wa = 8'((wa * 2) + d);
      wb = wb | 8'(int'(d) << k);
      if (k == 7) begin
        qa.push_back(wa);
        qb.push_back(wb);
        total++;
        k = 0;
      end else begin
        k++;
      end
    end
    check_all();
  endtask

  task automatic model_reset();
    k = 0;
    qa.delete();
    qb.delete();
    total = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #3 rst = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic r);
    for (int i = 0; i < 8; i++) cyc(1'b1, w[7-i], r);
  endtask

  initial begin
    logic [7:0] w;

    // Reset state
    #3;
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_data", 32'(data_a), 32'h0);
    chk("rst_cnt", 32'(cnt_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    #4 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_a), 32'h1);

    // Single word A5
    send_word(8'hA5, 1'b1);
    chk("single_valid", 32'(valid_a), 32'h1);
    chk("single_data", 32'(data_a), 32'hA5);
    chk("single_data_lsb", 32'(data_b), 32'hA5);
    chk("single_cnt", 32'(cnt_a), 32'h1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("single_drop", 32'(valid_a), 32'h0);

    // Gapped input
    do_reset();
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, w[7-i], 1'b1);
      if (i == 1 || i == 4) begin
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 1'b1, 1'b1);
          chk("gap_busy", 32'(busy_a), 32'h1);
        end
      end
    end
    chk("gap_data", 32'(data_a), 32'hA5);
    chk("gap_cnt", 32'(cnt_a), 32'h1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("gap_nopush", 32'(cnt_a), 32'h1);

    // Backpressure with a full FIFO
    do_reset();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    w = 8'h33;
    for (int i = 0; i < 7; i++) begin
      chk("bp_ready_hi", 32'(ready_a), 32'h1);
      cyc(1'b1, w[7-i], 1'b0);
    end
    chk("bp_ready_lo", 32'(ready_a), 32'h0);
    chk("bp_head", 32'(data_a), 32'h11);
    cyc(1'b1, w[0], 1'b1);
    chk("bp_pop_head", 32'(data_a), 32'h22);
    chk("bp_ready_back", 32'(ready_a), 32'h1);
    chk("bp_cnt_stalled", 32'(cnt_a), 32'h2);
    cyc(1'b1, w[0], 1'b0);
    chk("bp_cnt", 32'(cnt_a), 32'h3);
    cyc(1'b0, 1'b0, 1'b1);
    chk("bp_drain33", 32'(data_a), 32'h33);
    cyc(1'b0, 1'b0, 1'b1);
    chk("bp_empty", 32'(valid_a), 32'h0);

    // Asynchronous reset mid-word with a buffered word
    do_reset();
    send_word(8'h11, 1'b0);
    w = 8'h5A;
    for (int i = 0; i < 4; i++) cyc(1'b1, w[7-i], 1'b0);
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", 32'(valid_a), 32'h0);
    chk("mid_cnt", 32'(cnt_a), 32'h0);
    chk("mid_busy", 32'(busy_a), 32'h0);
    model_reset();
    #1 rst = 1'b0;
    send_word(8'hC3, 1'b0);
    chk("mid_word", 32'(data_a), 32'hC3);
    chk("mid_cnt1", 32'(cnt_a), 32'h1);

    // Streaming four back-to-back words; CNT_W=2 instance wraps to 0
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      w = 8'(n);
      for (int i = 0; i < 8; i++) begin
        chk("stream_ready", 32'(ready_a), 32'h1);
        cyc(1'b1, w[7-i], 1'b1);
      end
      chk("stream_data", 32'(data_a), 32'(n));
    end
    chk("stream_lsb", 32'(data_b), 32'h20);
    chk("stream_wrap", 32'(cnt_b), 32'h0);
    chk("stream_cnt", 32'(cnt_a), 32'h4);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
